// File: rtl/apb_soc_cfg_pkg.sv
// Register map offsets, CTRL field layout and readback helper for the SoC config block.
// No logic: constants and types only.
// Shared by the register file and its bench-facing decode.
package apb_soc_cfg_pkg;

    localparam int unsigned BOOT_SHADOW_OFS = 'h00;
    localparam int unsigned CTRL_OFS        = 'h04;
    localparam int unsigned ACTIVE_BOOT_OFS = 'h08;
    localparam int unsigned GP_BASE_OFS     = 'h10;

    localparam int unsigned CTRL_COMMIT_BIT = 0;
    localparam int unsigned CTRL_LOCK_BIT   = 1;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  commit_cnt;
        logic [4:0]  rsvd_lo;
        logic        pending;
        logic        lock;
        logic        commit;
    } ctrl_reg_t;

    // COMMIT is an action bit and always reads back as zero.
    function automatic logic [31:0] ctrl_rdata(input logic lock, input logic pending,
                                               input logic [7:0] cnt);
        ctrl_reg_t r;
        r            = '0;
        r.lock       = lock;
        r.pending    = pending;
        r.commit_cnt = cnt;
        return r;
    endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// APB wait-state generator: holds PREADY low for WAIT_STATES access cycles.
// Latency: WAIT_STATES cycles after the first access cycle; access_done is combinational.
// Backpressure: PREADY is the only stall; counter clears whenever the access phase ends.
module apb_wait_ctrl #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic psel,
    input  logic penable,
    output logic pready,
    output logic access_done
);

    localparam logic [1:0] WS_LIM = 2'(WAIT_STATES);

    logic [1:0] wait_cnt;
    logic       in_access;

    assign in_access = psel & penable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!in_access || access_done) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WS_LIM) begin
            wait_cnt <= wait_cnt + 2'd1;
        end
    end

    assign pready = (WAIT_STATES == 0) ? 1'b1 : (in_access && (wait_cnt == WS_LIM));

    // Gated by reset so a bus left mid-transfer during reset produces no response.
    assign access_done = in_access & pready & rst_n;

endmodule

// File: rtl/apb_soc_cfg_regs.sv
// APB config registers: shadow boot/GP words promoted to active outputs on COMMIT, sticky LOCK.
// Latency: response in the completing access cycle; active outputs update on that edge.
// Backpressure: WAIT_STATES PREADY-low cycles per access; no internal queuing.
module apb_soc_cfg_regs
    import apb_soc_cfg_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned NUM_GP         = 4,
    parameter logic [31:0] BOOT_RST_ADDR  = 32'h8000,
    parameter logic [31:0] GP_RST_VALUE   = 32'h0,
    parameter int unsigned WAIT_STATES    = 0
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [31:0]               boot_addr_o,
    output logic [NUM_GP*32-1:0]      gp_cfg_o,
    output logic                      cfg_update_o,
    output logic                      cfg_locked_o
);

    localparam int unsigned IDX_W = APB_ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] IDX_BOOT = IDX_W'(BOOT_SHADOW_OFS / 4);
    localparam logic [IDX_W-1:0] IDX_CTRL = IDX_W'(CTRL_OFS / 4);
    localparam logic [IDX_W-1:0] IDX_ACT  = IDX_W'(ACTIVE_BOOT_OFS / 4);
    localparam logic [IDX_W-1:0] IDX_GP0  = IDX_W'(GP_BASE_OFS / 4);

    logic [31:0]          boot_shadow;
    logic [31:0]          boot_active;
    logic [31:0]          gp_shadow [NUM_GP];
    logic [NUM_GP*32-1:0] gp_active;
    logic                 lock_q;
    logic                 pending_q;
    logic [7:0]           commit_cnt_q;
    logic                 cfg_update_q;

    logic                 access_done;
    logic [IDX_W-1:0]     word_idx;
    logic                 hit_boot, hit_ctrl, hit_act, any_gp, mapped;
    logic [NUM_GP-1:0]    gp_hit;
    logic [31:0]          gp_rdata;
    logic [31:0]          rd_data;
    logic                 slv_err, wr_ok, do_commit, set_lock, shadow_wr;
    logic                 unused_addr_lsb;

    apb_wait_ctrl #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_ctrl (
        .clk         (HCLK),
        .rst_n       (HRESETn),
        .psel        (PSEL),
        .penable     (PENABLE),
        .pready      (PREADY),
        .access_done (access_done)
    );

    assign word_idx        = PADDR[APB_ADDR_WIDTH-1:2];
    assign unused_addr_lsb = ^PADDR[1:0];

    always_comb begin
        hit_boot = (word_idx == IDX_BOOT);
        hit_ctrl = (word_idx == IDX_CTRL);
        hit_act  = (word_idx == IDX_ACT);
        gp_hit   = '0;
        gp_rdata = '0;
        for (int i = 0; i < NUM_GP; i++) begin
            if (word_idx == IDX_GP0 + IDX_W'(i)) begin
                gp_hit[i] = 1'b1;
                gp_rdata  = gp_shadow[i];
            end
        end
    end

    assign any_gp = |gp_hit;
    assign mapped = hit_boot | hit_ctrl | hit_act | any_gp;

    // ACTIVE_BOOT is never writable; everything else writable is frozen by LOCK.
    assign slv_err = !mapped
                   | (PWRITE & hit_act)
                   | (PWRITE & lock_q & (hit_boot | hit_ctrl | any_gp));

    assign wr_ok     = access_done & PWRITE & !slv_err;
    assign do_commit = wr_ok & hit_ctrl & PWDATA[CTRL_COMMIT_BIT];
    assign set_lock  = wr_ok & hit_ctrl & PWDATA[CTRL_LOCK_BIT];
    assign shadow_wr = wr_ok & (hit_boot | any_gp);

    always_comb begin
        rd_data = '0;
        if (hit_boot)      rd_data = boot_shadow;
        else if (hit_ctrl) rd_data = ctrl_rdata(lock_q, pending_q, commit_cnt_q);
        else if (hit_act)  rd_data = boot_active;
        else if (any_gp)   rd_data = gp_rdata;
    end

    assign PRDATA  = (access_done && !PWRITE && !slv_err) ? rd_data : '0;
    assign PSLVERR = access_done & slv_err;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            boot_shadow <= BOOT_RST_ADDR;
            for (int i = 0; i < NUM_GP; i++) gp_shadow[i] <= GP_RST_VALUE;
        end else begin
            if (wr_ok && hit_boot) boot_shadow <= PWDATA;
            for (int i = 0; i < NUM_GP; i++) begin
                if (wr_ok && gp_hit[i]) gp_shadow[i] <= PWDATA;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            boot_active <= BOOT_RST_ADDR;
            gp_active   <= {NUM_GP{GP_RST_VALUE}};
        end else if (do_commit) begin
            boot_active <= boot_shadow;
            for (int i = 0; i < NUM_GP; i++) gp_active[32*i +: 32] <= gp_shadow[i];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lock_q       <= 1'b0;
            pending_q    <= 1'b0;
            commit_cnt_q <= '0;
            cfg_update_q <= 1'b0;
        end else begin
            cfg_update_q <= do_commit;
            if (set_lock)       lock_q    <= 1'b1;
            if (do_commit)      pending_q <= 1'b0;
            else if (shadow_wr) pending_q <= 1'b1;
            if (do_commit)      commit_cnt_q <= commit_cnt_q + 8'd1;
        end
    end

    assign boot_addr_o  = boot_active;
    assign gp_cfg_o     = gp_active;
    assign cfg_update_o = cfg_update_q;
    assign cfg_locked_o = lock_q;

endmodule

// File: doc/apb_soc_cfg_regs.md
Name: apb_soc_cfg_regs

Overview:
- APB slave holding the MCU's runtime system configuration: boot address plus NUM_GP general-purpose 32-bit configuration words.
- Successor to the compile-time SoC parameters. Values are writable at run time into shadow registers, and reach the active outputs only on an explicit COMMIT.
- Adds a sticky LOCK, configurable APB wait states, error responses and a commit counter.
- Sits on the peripheral APB bus next to the other SoC control peripherals. Drives the boot-address input of the core and the misc configuration inputs.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR used for decode (byte address, word aligned).
- NUM_GP, 4, number of general-purpose config words (1..16).
- BOOT_RST_ADDR, 32'h8000, reset value of boot address (ROM start).
- GP_RST_VALUE, 32'h0, reset value of every GP word (shadow and active).
- WAIT_STATES, 0, PREADY-low cycles inserted in each access phase (0..3).

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- PADDR  in  APB_ADDR_WIDTH  APB address
- PWDATA  in  32  write data
- PWRITE  in  1  1 = write
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PRDATA  out  32  read data, valid when PREADY=1
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error, valid when PREADY=1
- boot_addr_o  out  32  active boot address
- gp_cfg_o  out  NUM_GP*32  active GP words; word i is [32i+31:32i]
- cfg_update_o  out  1  one-cycle pulse when active values change via commit
- cfg_locked_o  out  1  LOCK state

Behaviour:
- Reset (async, HRESETn=0):
  - Shadow and active boot address = BOOT_RST_ADDR; shadow and active GP words = GP_RST_VALUE.
  - LOCK=0, PENDING=0, commit_cnt=0, wait counter=0.
  - PRDATA=0, PSLVERR=0, cfg_update_o=0.
  - PREADY=1 if WAIT_STATES=0, else 0.
  - Reset mid-transfer aborts it; no register is changed.
- Register map (PADDR[APB_ADDR_WIDTH-1:2] word index):
  - 0x00 BOOT_SHADOW: rw, reads shadow.
  - 0x04 CTRL:
    - bit0 COMMIT: w1 action, reads 0.
    - bit1 LOCK: w1 sets, sticky until reset.
    - bit2 PENDING: ro; set by any accepted shadow write, cleared by commit.
    - bits[15:8] commit_cnt: ro, 8-bit, wraps 255->0.
    - Other bits read 0.
  - 0x08 ACTIVE_BOOT: ro, reads boot_addr_o.
  - 0x0C reserved.
  - 0x10+4i GP_SHADOW[i], i<NUM_GP: rw.
  - Any other address: PSLVERR=1 and PRDATA=0.
- APB timing:
  - Setup phase is PSEL & !PENABLE. The access phase begins the next cycle.
  - The wait counter counts WAIT_STATES cycles with PREADY=0, then PREADY=1 for exactly one cycle. The counter is cleared when PSEL drops.
  - PRDATA, PSLVERR and all register effects occur only in the cycle with PSEL & PENABLE & PREADY.
  - With WAIT_STATES=0 the transfer completes in the first access cycle.
- Writes:
  - A write to a ro address (ACTIVE_BOOT) sets PSLVERR and has no effect.
  - Writes to shadow registers while LOCK=1: PSLVERR=1, no change.
  - Writes to CTRL while LOCK=1: PSLVERR=1, no change.
- Commit (accepted CTRL write with bit0=1):
  - Next rising edge: active <= shadow for all words, PENDING<=0, commit_cnt+=1.
  - cfg_update_o=1 in the following cycle only.
  - A commit with PENDING=0 is still counted and still pulses.
  - COMMIT and LOCK set in the same write: the commit takes effect and LOCK sets on the same edge.
- Reads return the register value before any same-cycle update.
- cfg_locked_o mirrors LOCK directly (registered).

Decomposition:
- Package apb_soc_cfg_pkg holds the address offset constants (BOOT_SHADOW, CTRL, ACTIVE_BOOT, GP_BASE), the CTRL bit indices and a ctrl_reg_t packed struct.
- One sub-module is natural: apb_wait_ctrl, which takes PSEL/PENABLE and WAIT_STATES and produces PREADY plus an access_done strobe. The register file stays in the top.

Test Plan:
- Reset -> boot_addr_o=32'h8000; read CTRL returns 0; gp_cfg_o all 0; cfg_update_o=0.
- Write BOOT_SHADOW=32'h0000_1000 -> boot_addr_o stays 32'h8000 and CTRL.PENDING=1. Then write CTRL=1 -> boot_addr_o=32'h1000 one edge later, cfg_update_o high for 1 cycle, CTRL reads 32'h0000_0100.
- Write CTRL=3 after GP_SHADOW[2]=32'hA5A5_0F0F -> gp word 2 updated and cfg_locked_o=1. Then write BOOT_SHADOW=32'h2000 -> PSLVERR=1 and shadow unchanged. Then write CTRL=1 -> PSLVERR=1 and commit_cnt stays 1.
- WAIT_STATES=2: read 0x08 -> PREADY low for exactly 2 access cycles, then PRDATA=active boot with PSLVERR=0.
- Access 0x0C, 0x10+4*NUM_GP, or a write to 0x08 -> PSLVERR=1, PRDATA=0, no state change.
- 256 commits -> commit_cnt wraps to 0. Assert HRESETn mid-access-phase (WAIT_STATES=3) -> all outputs return to reset values immediately and the shadow write is not performed.
